// File: rtl/serial_nibble_rx_pkg.sv
// rtl/serial_nibble_rx_pkg.sv - shared types and constants for the serial nibble receiver
//   package serial_rx_pkg
//     rx_state_t     : receiver state encoding (IDLE, START, DATA, PARITY, STOP)
//     BIT_CYCLES_DEF : default clocks per serial bit
//     NIB_W          : width of one P,Q,R,S code
package serial_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int BIT_CYCLES_DEF = 4;
    localparam int NIB_W          = 4;

endpackage

// File: rtl/serial_nibble_rx_if.sv
// rtl/serial_nibble_rx_if.sv - serial line and nibble handshake bundle
//   sdata     : serial line into the receiver (idles high)
//   nib       : buffered code, nib[3]=P .. nib[0]=S
//   nib_valid : head of buffer is valid
//   nib_ready : consumer accepts nib this cycle
//   par_err   : one-cycle pulse, parity failure
//   frm_err   : one-cycle pulse, stop bit sampled low
//   ovf_err   : one-cycle pulse, good frame dropped on a full buffer
//   modport master : receiver side
//   modport slave  : line driver / consumer side
interface serial_nibble_rx_if;
    import serial_rx_pkg::*;

    logic             sdata;
    logic [NIB_W-1:0] nib;
    logic             nib_valid;
    logic             nib_ready;
    logic             par_err;
    logic             frm_err;
    logic             ovf_err;

    modport master (
        input  sdata,
        input  nib_ready,
        output nib,
        output nib_valid,
        output par_err,
        output frm_err,
        output ovf_err
    );

    modport slave (
        output sdata,
        output nib_ready,
        input  nib,
        input  nib_valid,
        input  par_err,
        input  frm_err,
        input  ovf_err
    );

endinterface

// File: rtl/nibble_fifo2.sv
// rtl/nibble_fifo2.sv - two-entry FIFO holding received nibbles
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset, empties the FIFO and zeroes storage
//   i_push      : write request; accepted when not full or when popping this cycle
//   i_push_data : data to write
//   o_full      : two entries held
//   i_pop       : consumer ready; a pop happens when o_valid is also high
//   o_valid     : at least one entry held
//   o_data      : head entry
module nibble_fifo2
    import serial_rx_pkg::*;
#(
    parameter int W = NIB_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_push_data,
    output logic         o_full,
    input  logic         i_pop,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic [W-1:0] r_mem [2];
    logic         r_rd_ptr;
    logic         r_wr_ptr;
    logic [1:0]   r_count;

    logic         w_pop;
    logic         w_push;

    assign w_pop  = i_pop && (r_count != 2'd0);
    // A full FIFO still takes a write when the head leaves in the same cycle;
    // both pointers then refer to the same slot and the write lands behind the read.
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != 2'd0);
    assign o_full  = (r_count == 2'd2);

endmodule

// File: rtl/serial_nibble_rx.sv
// rtl/serial_nibble_rx.sv - serial receiver rebuilding P,Q,R,S codes with parity/framing checks
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : serial_nibble_rx_if.master (sdata in, nib/nib_valid/nib_ready handshake,
//           par_err/frm_err/ovf_err pulses)
//   BIT_CYCLES : clocks per serial bit, even and at least 4
module serial_nibble_rx
    import serial_rx_pkg::*;
#(
    parameter int BIT_CYCLES = BIT_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_nibble_rx_if.master  bus
);

    localparam int CW = $clog2(BIT_CYCLES);

    localparam logic [CW-1:0] C_HALF = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [CW-1:0] C_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_START  = START;
    localparam logic [2:0] S_DATA   = DATA;
    localparam logic [2:0] S_PARITY = PARITY;
    localparam logic [2:0] S_STOP   = STOP;

    logic             r_sync1;
    logic             r_sync2;
    logic [2:0]       r_state;
    logic [CW-1:0]    r_cyc_cnt;
    logic [1:0]       r_bit_cnt;
    logic [NIB_W-1:0] r_shift;
    logic             r_par_bit;
    logic             r_par_err;
    logic             r_frm_err;
    logic             r_ovf_err;

    logic             w_sdata_s;
    logic             w_tick;
    logic             w_stop_done;
    logic             w_par_bad;
    logic             w_full;
    logic             w_valid;
    logic             w_pop;
    logic             w_push;
    logic [NIB_W-1:0] w_head;

    // Both flops reset high so a reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.sdata;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sdata_s   = r_sync2;
    assign w_tick      = (r_cyc_cnt == C_LAST);
    assign w_stop_done = (r_state == S_STOP) && w_tick;
    assign w_par_bad   = (^r_shift) ^ r_par_bit;
    assign w_pop       = w_valid && bus.nib_ready;

    // Push is combinational on the stop sample so the entry is visible the next cycle.
    assign w_push = w_stop_done && w_sdata_s && !w_par_bad && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cyc_cnt <= '0;
            r_bit_cnt <= 2'd0;
            r_shift   <= '0;
            r_par_bit <= 1'b0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
            r_ovf_err <= 1'b0;
        end else begin
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
            r_ovf_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_sdata_s) begin
                        r_cyc_cnt <= '0;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    if (r_cyc_cnt == C_HALF) begin
                        // Re-checking mid-bit filters glitches shorter than half a bit.
                        r_cyc_cnt <= '0;
                        r_bit_cnt <= 2'd0;
                        r_state   <= w_sdata_s ? S_IDLE : S_DATA;
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt + C_ONE;
                    end
                end
                S_DATA: begin
                    r_cyc_cnt <= w_tick ? '0 : r_cyc_cnt + C_ONE;
                    if (w_tick) begin
                        r_shift   <= {r_shift[NIB_W-2:0], w_sdata_s};
                        r_bit_cnt <= r_bit_cnt + 2'd1;
                        if (r_bit_cnt == 2'd3) begin
                            r_state <= S_PARITY;
                        end
                    end
                end
                S_PARITY: begin
                    r_cyc_cnt <= w_tick ? '0 : r_cyc_cnt + C_ONE;
                    if (w_tick) begin
                        r_par_bit <= w_sdata_s;
                        r_state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    r_cyc_cnt <= w_tick ? '0 : r_cyc_cnt + C_ONE;
                    if (w_tick) begin
                        // Framing beats parity beats overflow; exactly one outcome per frame.
                        r_frm_err <= !w_sdata_s;
                        r_par_err <= w_sdata_s && w_par_bad;
                        r_ovf_err <= w_sdata_s && !w_par_bad && w_full && !w_pop;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_cyc_cnt <= '0;
                end
            endcase
        end
    end

    nibble_fifo2 #(
        .W (NIB_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (r_shift),
        .o_full      (w_full),
        .i_pop       (bus.nib_ready),
        .o_valid     (w_valid),
        .o_data      (w_head)
    );

    assign bus.nib       = w_head;
    assign bus.nib_valid = w_valid;
    assign bus.par_err   = r_par_err;
    assign bus.frm_err   = r_frm_err;
    assign bus.ovf_err   = r_ovf_err;

endmodule

// File: doc/serial_nibble_rx.md
# serial_nibble_rx

Serial front-end for the nibble decryption stage. It receives encrypted 4-bit codes on a single serial line and rebuilds each code as the parallel P,Q,R,S word that the decryptor consumes. Each frame has a start bit, 4 data bits, an even-parity bit and a stop bit. Good nibbles go into a 2-entry buffer with a valid/ready handshake; bad frames are dropped and flagged.

## Interface
Parameters:
- BIT_CYCLES, 4, clocks per serial bit; must be even and ≥4.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sdata  input  1  serial line, asynchronous to clk; idles high.
- nib  output  4  buffered code; nib[3]=P, nib[2]=Q, nib[1]=R, nib[0]=S.
- nib_valid  output  1  head of buffer is valid.
- nib_ready  input  1  consumer accepts nib this cycle when nib_valid=1.
- par_err  output  1  one-cycle pulse: parity failure, frame dropped.
- frm_err  output  1  one-cycle pulse: stop bit sampled 0, frame dropped.
- ovf_err  output  1  one-cycle pulse: good frame dropped because the buffer is full.

## Operation
- sdata passes through a 2-flop synchronizer, giving sdata_s. Both flops reset to 1.
- Frame order on the line: start(0), P, Q, R, S (P first), parity, stop(1).
- Parity is even: P^Q^R^S^parity must equal 0.
- State machine states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when sdata_s==0, clear cyc_cnt and go to START.
  - START: at cyc_cnt==BIT_CYCLES/2-1, sample sdata_s. A 1 is a false start: return to IDLE with no error. A 0 clears cyc_cnt and bit_cnt and goes to DATA.
  - DATA: sample at each cyc_cnt==BIT_CYCLES-1 and shift the bit into a 4-bit register, MSB first. After the 4th sample, go to PARITY.
  - PARITY: sample once, then go to STOP.
  - STOP: sample once and return to IDLE in the same transition.
- Result of the STOP sample, in priority order:
  - stop==0: frm_err.
  - parity bad: par_err.
  - buffer full and no pop this cycle: ovf_err.
  - otherwise: push the nibble.
- Exactly one of {push, frm_err, par_err, ovf_err} occurs per completed frame.
- Buffer: 2 entries, FIFO order.
  - Pop when nib_valid && nib_ready.
  - A push while full succeeds if a pop happens in the same cycle.
  - Push and pop together while holding 1 entry keeps the count at 1.
- nib is held stable while nib_valid=1 and no pop occurs.

## Timing
- Reset values: nib=0, nib_valid=0, par_err=0, frm_err=0, ovf_err=0, state=IDLE, buffer empty, counters 0.
- Reset asserted mid-frame discards the partial frame and all buffered data. After release, the block waits for a fresh falling edge in IDLE.
- Let T0 be the cycle IDLE sees sdata_s==0 (2 cycles after the line falls).
- Sample points relative to T0:
  - start check: T0+BIT_CYCLES/2.
  - data bit k (k=0..3): T0+BIT_CYCLES/2+(k+1)·BIT_CYCLES.
  - parity: T0+BIT_CYCLES/2+5·BIT_CYCLES.
  - stop: Ts = T0+BIT_CYCLES/2+6·BIT_CYCLES.
- At Ts+1: nib_valid rises if the buffer was empty, or exactly one error pulse is high for that single cycle.
- State is IDLE at Ts+1, so back-to-back frames with a one-bit stop are accepted.
- Pop-to-next-valid: if a second entry is present, nib shows it in the cycle after the pop with no bubble.
- Arithmetic:
  - cyc_cnt has width $clog2(BIT_CYCLES) and wraps to 0 at BIT_CYCLES-1.
  - bit_cnt is 2 bits.
  - Buffer count is 2 bits, range 0..2.

## Structure
- Package serial_rx_pkg holds:
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP).
  - BIT_CYCLES_DEF=4.
  - NIB_W=4.
- Sub-module nibble_fifo2: 2-entry buffer of NIB_W bits with push/full/pop/valid, reset by the same asynchronous active-low rst_n.
- The top level holds the synchronizer, state machine, counters, shift register and error logic.

## Test plan
All scenarios use BIT_CYCLES=4.
- Good frame: line 0,1,0,1,1,1,1 (P=1,Q=0,R=1,S=1, parity=1, stop=1), nib_ready=1 → nib=4'b1011 with nib_valid high 1 cycle at Ts+1; no error pulses.
- Parity error: same data with parity=0 → par_err pulses once, nib_valid stays 0. False start (line low 1 cycle only) → no pulse, state returns to IDLE.
- Framing error: code 0000, parity 0, stop 0 → frm_err pulses once. A following good frame for 0110 still yields nib=4'b0110.
- Backpressure: nib_ready=0, send 0001, 0010, 0100 back to back → first two are buffered, the third raises ovf_err. Then nib_ready=1 pops 0001 then 0010 on consecutive cycles.
- Reset mid-frame: rst_n low during DATA, with 1 entry buffered → all outputs 0 immediately. A frame after release yields a correct nib with no stale data.
- Full push with pop: buffer full, nib_ready=1 at Ts → push accepted, no ovf_err, count stays 2.
